// File: rtl/model_buffer_reader.sv
// rtl/model_buffer_reader.sv - vertex and index buffer readers with 1-cycle memory streams
module model_buffer_reader_stream #(
    parameter int DW    = 24,
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic [AW:0]   count,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          read_en,
    output logic [DW-1:0] rd_data,
    output logic          dv,
    output logic          last,
    output logic          streaming
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    logic [DW-1:0] mem [DEPTH];
    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] ptr;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_in;
    logic          rd_fire;
    logic          at_end;

    assign cnt_in    = (count > DEPTH_W) ? DEPTH_W : count;
    assign at_end    = ({1'b0, ptr} == (cnt - ONE));
    assign streaming = (state == S_STREAM);

    // start wins over read_en in every state, so a restart never emits a beat
    always_comb begin
        state_nxt = state;
        rd_fire   = 1'b0;
        case (state)
            S_STREAM: begin
                if (start) begin
                    state_nxt = (cnt_in == '0) ? S_DONE : S_STREAM;
                end else if (read_en) begin
                    rd_fire = 1'b1;
                    if (at_end) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_nxt = (cnt_in == '0) ? S_DONE : S_STREAM;
                end
            end
        endcase
    end

    // storage survives reset; nonblocking write gives read-first behaviour
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= S_IDLE;
            ptr     <= '0;
            cnt     <= '0;
            dv      <= 1'b0;
            last    <= 1'b0;
            rd_data <= '0;
        end else begin
            state <= state_nxt;
            dv    <= rd_fire;
            last  <= rd_fire && at_end;
            if (start) begin
                ptr <= '0;
                cnt <= cnt_in;
            end else if (rd_fire) begin
                ptr <= ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_data <= mem[ptr];
            end
        end
    end

endmodule

module model_buffer_reader #(
    parameter int  DATAWIDTH          = 24,
    parameter int  MAX_VERTEX_COUNT   = 4096,
    parameter int  MAX_TRIANGLE_COUNT = 4096,
    localparam int AW                 = $clog2(MAX_VERTEX_COUNT),
    localparam int TW                 = $clog2(MAX_TRIANGLE_COUNT)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_start,
    input  logic [AW:0]            i_vertex_count,
    input  logic [TW:0]            i_triangle_count,
    output logic                   o_busy,
    input  logic                   i_wr_vertex_en,
    input  logic [AW-1:0]          i_wr_vertex_addr,
    input  logic [3*DATAWIDTH-1:0] i_wr_vertex_data,
    input  logic                   i_wr_index_en,
    input  logic [TW-1:0]          i_wr_index_addr,
    input  logic [3*AW-1:0]        i_wr_index_data,
    input  logic                   i_vertex_read_en,
    output logic [3*DATAWIDTH-1:0] o_vertex,
    output logic                   o_vertex_dv,
    output logic                   o_vertex_last,
    input  logic                   i_index_read_en,
    output logic [3*AW-1:0]        o_index_data,
    output logic                   o_index_dv,
    output logic                   o_index_last
);

    logic vertex_streaming;
    logic index_streaming;

    model_buffer_reader_stream #(
        .DW    (3*DATAWIDTH),
        .DEPTH (MAX_VERTEX_COUNT),
        .AW    (AW)
    ) u_vertex (
        .clk       (clk),
        .rstn      (rstn),
        .start     (i_start),
        .count     (i_vertex_count),
        .wr_en     (i_wr_vertex_en),
        .wr_addr   (i_wr_vertex_addr),
        .wr_data   (i_wr_vertex_data),
        .read_en   (i_vertex_read_en),
        .rd_data   (o_vertex),
        .dv        (o_vertex_dv),
        .last      (o_vertex_last),
        .streaming (vertex_streaming)
    );

    model_buffer_reader_stream #(
        .DW    (3*AW),
        .DEPTH (MAX_TRIANGLE_COUNT),
        .AW    (TW)
    ) u_index (
        .clk       (clk),
        .rstn      (rstn),
        .start     (i_start),
        .count     (i_triangle_count),
        .wr_en     (i_wr_index_en),
        .wr_addr   (i_wr_index_addr),
        .wr_data   (i_wr_index_data),
        .read_en   (i_index_read_en),
        .rd_data   (o_index_data),
        .dv        (o_index_dv),
        .last      (o_index_last),
        .streaming (index_streaming)
    );

    assign o_busy = vertex_streaming | index_streaming;

endmodule
